uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter with input FIFO.
//   tx_state_t  - transmit FSM state encoding
//   PARITY_*    - legal values of the PARITY parameter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, WIDTH x DEPTH (DEPTH a power of two).
//   clk, reset   - clock, asynchronous active-high reset (clears pointers only)
//   i_wr_en      - push request, accepted when the registered full flag is low
//   i_wr_data    - data to push
//   i_rd_en      - pop request, honoured when the registered empty flag is low
//   o_rd_data    - head entry (valid while o_empty is low)
//   o_full       - DEPTH entries held
//   o_empty      - no entries held
//   o_count      - number of entries held
//   o_wr_reject  - push attempted while full (data discarded)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_wr_reject
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_next;

    assign w_push = i_wr_en && !r_full;
    assign w_pop  = i_rd_en && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage is never reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data   = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;
    assign o_wr_reject = i_wr_en && r_full;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO.
//   clk, reset - clock, asynchronous active-high reset
//   wr_en      - push wr_data into the FIFO
//   wr_data    - DATA_BITS-wide character to send
//   ovf_clr    - clears the sticky overflow flag (a simultaneous overflow wins)
//   full/empty/count - FIFO status
//   busy       - transmitter FSM not idle
//   overflow   - sticky: a push was attempted while full
//   tx_done    - one-cycle pulse coinciding with the last stop-bit clock on txd
//   txd        - serial output, idle high, driven from a flop
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV       = 5208,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 ovf_clr,
    output logic                 full,
    output logic                 empty,
    output logic [CW-1:0]        count,
    output logic                 busy,
    output logic                 overflow,
    output logic                 tx_done,
    output logic                 txd
);
    localparam int   BW        = $clog2(DIV);
    localparam int   IW        = $clog2(DATA_BITS);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    tx_state_t            r_state;
    logic [BW-1:0]        r_baud;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_tx_done;
    logic                 r_overflow;

    logic [DATA_BITS-1:0] w_head;
    logic                 w_empty;
    logic                 w_wr_reject;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_head_par;
    logic                 w_txd_next;

    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_bit_end  = (r_baud == '0);
    assign w_head_par = (PARITY == PARITY_ODD) ? ~(^w_head) : (^w_head);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .i_rd_en     (w_pop),
        .o_rd_data   (w_head),
        .o_full      (full),
        .o_empty     (w_empty),
        .o_count     (count),
        .o_wr_reject (w_wr_reject)
    );

    // Set has priority over clear so an overflow is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_wr_reject) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Line level for the current state; registered below, so txd trails the
    // state by one clock and each bit still lasts exactly DIV clocks.
    always_comb begin
        w_txd_next = 1'b1;
        case (r_state)
            ST_START: w_txd_next = 1'b0;
            ST_DATA:  w_txd_next = r_shift[0];
            ST_PAR:   w_txd_next = r_par_bit;
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_txd     <= w_txd_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_par_bit <= w_head_par;
                        r_baud    <= BW'(DIV - 1);
                        r_state   <= ST_START;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud    <= BW'(DIV - 1);
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= BW'(DIV - 1);
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                            r_bit_idx  <= '0;
                            r_stop_idx <= 1'b0;
                            r_state    <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IW'(1);
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                ST_PAR: begin
                    if (w_bit_end) begin
                        r_baud     <= BW'(DIV - 1);
                        r_stop_idx <= 1'b0;
                        r_state    <= ST_STOP;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == STOP_LAST) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_tx_done  <= 1'b1;
                        end else begin
                            r_stop_idx <= 1'b1;
                            r_baud     <= BW'(DIV - 1);
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign empty    = w_empty;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign tx_done  = r_tx_done;
    assign txd      = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three instances (PARITY 0/1/2, the odd-parity one with two
// stop bits), DIV=4, DEPTH=4. Frames are checked clock by clock on txd.
module tb_uart_tx_fifo;
    localparam int NDUT  = 3;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en_v   [NDUT];
    logic [7:0]    wr_data_v [NDUT];
    logic          ovf_clr_v [NDUT];
    logic          full_v    [NDUT];
    logic          empty_v   [NDUT];
    logic [CW-1:0] count_v   [NDUT];
    logic          busy_v    [NDUT];
    logic          ovf_v     [NDUT];
    logic          done_v    [NDUT];
    logic          txd_v     [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            uart_tx_fifo #(
                .DATA_BITS (8),
                .DEPTH     (DEPTH),
                .PARITY    (gi),
                .STOP_BITS ((gi == 2) ? 2 : 1),
                .DIV       (DIV)
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (wr_en_v[gi]),
                .wr_data  (wr_data_v[gi]),
                .ovf_clr  (ovf_clr_v[gi]),
                .full     (full_v[gi]),
                .empty    (empty_v[gi]),
                .count    (count_v[gi]),
                .busy     (busy_v[gi]),
                .overflow (ovf_v[gi]),
                .tx_done  (done_v[gi]),
                .txd      (txd_v[gi])
            );
        end
    endgenerate

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [11:0] frame;  // bit i = i-th bit on the line
        int         len;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, idx, $time, act, exp);
        end
    endtask

    // Called at a negedge; pushes on the following rising edge, returns at the next negedge.
    task automatic push(input int idx, input logic [7:0] d);
        wr_en_v[idx]   = 1'b1;
        wr_data_v[idx] = d;
        @(negedge clk);
        wr_en_v[idx] = 1'b0;
    endtask

    // One idle-high sample, then every clock of the frame; tx_done only on the last clock.
    task automatic check_frame(input int idx, input logic [11:0] frame, input int len);
        logic last;
        @(negedge clk);
        chk("gap_txd", idx, txd_v[idx], 1'b1);
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                last = (b == len - 1) && (c == DIV - 1);
                chk("txd_bit", idx, txd_v[idx], frame[b]);
                chk("tx_done", idx, done_v[idx], last);
                if (!last) chk("busy_frame", idx, busy_v[idx], 1'b1);
            end
        end
    endtask

    task automatic check_idle(input int idx);
        @(negedge clk);
        chk("idle_txd", idx, txd_v[idx], 1'b1);
        chk("idle_busy", idx, busy_v[idx], 1'b0);
        chk("idle_empty", idx, empty_v[idx], 1'b1);
        chk("idle_count", idx, count_v[idx], 0);
    endtask

    // Five pushes in consecutive cycles, then fill-to-full, overflow and clear.
    task automatic scen_fill();
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wr_en_v[0]   = 1'b1;
        wr_data_v[0] = bytes[0];
        fork
            begin
                for (int k = 1; k < 5; k++) begin
                    @(negedge clk);
                    chk("full_at_push", 0, full_v[0], 1'b0);
                    wr_data_v[0] = bytes[k];
                end
                @(negedge clk);
                chk("fill_full", 0, full_v[0], 1'b1);
                chk("fill_count", 0, count_v[0], 4);
                chk("fill_ovf0", 0, ovf_v[0], 1'b0);
                wr_data_v[0] = 8'h66;
                @(negedge clk);
                chk("ovf_set", 0, ovf_v[0], 1'b1);
                chk("ovf_count", 0, count_v[0], 4);
                wr_data_v[0] = 8'h77;
                ovf_clr_v[0] = 1'b1;
                @(negedge clk);
                chk("ovf_set_wins", 0, ovf_v[0], 1'b1);
                wr_en_v[0] = 1'b0;
                @(negedge clk);
                chk("ovf_cleared", 0, ovf_v[0], 1'b0);
                chk("ovf_count2", 0, count_v[0], 4);
                ovf_clr_v[0] = 1'b0;
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 5; k++) check_frame(0, {2'b00, 1'b1, bytes[k], 1'b0}, 10);
            end
        join
        check_idle(0);
    endtask

    // Push and pop in the same cycle at count=2.
    task automatic scen_pushpop();
        logic [7:0] bytes [4];
        logic got;
        bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
        got = 1'b0;
        wr_en_v[0]   = 1'b1;
        wr_data_v[0] = bytes[0];
        fork
            begin
                @(negedge clk);
                wr_data_v[0] = bytes[1];
                @(negedge clk);
                wr_data_v[0] = bytes[2];
                @(negedge clk);
                wr_en_v[0] = 1'b0;
                chk("pp_count2", 0, count_v[0], 2);
                for (int i = 0; i < 200 && !got; i++) begin
                    @(negedge clk);
                    if (done_v[0]) got = 1'b1;
                end
                chk("pp_done_seen", 0, got, 1'b1);
                wr_en_v[0]   = 1'b1;
                wr_data_v[0] = bytes[3];
                @(negedge clk);
                wr_en_v[0] = 1'b0;
                chk("pp_count_same", 0, count_v[0], 2);
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) check_frame(0, {2'b00, 1'b1, bytes[k], 1'b0}, 10);
            end
        join
        check_idle(0);
    endtask

    // Reset during data bit 3 with one more byte queued.
    task automatic scen_reset();
        push(0, 8'h25);
        push(0, 8'h99);
        for (int i = 0; i < 18; i++) @(negedge clk);
        chk("pre_rst_txd", 0, txd_v[0], 1'b0);
        chk("pre_rst_busy", 0, busy_v[0], 1'b1);
        chk("pre_rst_count", 0, count_v[0], 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_txd_async", 0, txd_v[0], 1'b1);
        chk("rst_count", 0, count_v[0], 0);
        chk("rst_busy", 0, busy_v[0], 1'b0);
        chk("rst_empty", 0, empty_v[0], 1'b1);
        chk("rst_done", 0, done_v[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_txd", 0, txd_v[0], 1'b1);
            chk("post_rst_done", 0, done_v[0], 1'b0);
        end
        push(0, 8'h2D);
        check_frame(0, 12'h25A, 10);
        check_idle(0);
    endtask

    initial begin
        logic [7:0] d;
        vecs[0] = '{0, 8'h2D, 12'h25A, 10};
        vecs[1] = '{0, 8'hFF, 12'h3FE, 10};
        vecs[2] = '{0, 8'h00, 12'h200, 10};
        vecs[3] = '{1, 8'h07, 12'h60E, 11};
        vecs[4] = '{1, 8'hA5, 12'h54A, 11};
        vecs[5] = '{1, 8'h01, 12'h602, 11};
        vecs[6] = '{2, 8'h07, 12'hC0E, 12};
        vecs[7] = '{2, 8'h80, 12'hD00, 12};
        vecs[8] = '{2, 8'h00, 12'hE00, 12};
        for (int i = 0; i < NDUT; i++) begin
            wr_en_v[i]   = 1'b0;
            wr_data_v[i] = 8'h00;
            ovf_clr_v[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_count", i, count_v[i], 0);
            chk("rst_empty", i, empty_v[i], 1'b1);
            chk("rst_full", i, full_v[i], 1'b0);
            chk("rst_ovf", i, ovf_v[i], 1'b0);
            chk("rst_done", i, done_v[i], 1'b0);
            chk("rst_busy", i, busy_v[i], 1'b0);
            chk("rst_txd", i, txd_v[i], 1'b1);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            $display("vector %0d: dut%0d data=%02h", v, vecs[v].dut, vecs[v].data);
            push(vecs[v].dut, vecs[v].data);
            check_frame(vecs[v].dut, vecs[v].frame, vecs[v].len);
            check_idle(vecs[v].dut);
        end

        $display("sequence: five back-to-back pushes, full and overflow");
        scen_fill();
        $display("sequence: push and pop in the same cycle");
        scen_pushpop();

        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom_range(0, 255));
            $display("wrap frame %0d: data=%02h", k, d);
            push(0, d);
            check_frame(0, {2'b00, 1'b1, d, 1'b0}, 10);
            check_idle(0);
        end

        $display("sequence: reset mid-frame");
        scen_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
